mul_div_unit: RTL

- Iterative, parametrised RV M-extension execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the execute stage; the pipeline holds while busy.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.
- Valid/ready handshake, flush (kill) support and writeback tag passthrough.

---
 rtl/mul_div_unit_pkg.sv | 20 ++
 rtl/mul_div_step.sv | 35 +++
 rtl/mul_div_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared types and operation-decode helpers for the iterative M-extension unit.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} mulDivOperation;

  typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} mdState;

  function automatic logic is_div(input mulDivOperation op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic a_signed(input mulDivOperation op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic b_signed(input mulDivOperation op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step.
// Purely combinational; accumulator is {high/remainder, low/multiplier-or-quotient}.
module mul_div_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic              div_mode_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_new;

  always_comb begin
    addend  = acc_i[0] ? opnd_i : '0;
    sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, addend};
    rem_sh  = acc_i[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, opnd_i};
    // A clear borrow bit means the trial subtraction fits: keep it and set the quotient bit.
    q_bit   = ~diff[XLEN];
    rem_new = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    acc_o   = '0;
    if (div_mode_i) begin
      acc_o = {rem_new, acc_i[XLEN-2:0], q_bit};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV M-extension execute unit (MUL*/DIV*/REM*), one bit per cycle.
// Result XLEN+2 cycles after accept (2 for divide special cases); start only taken while ready, kill aborts.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             kill,
  output logic             ready,
  output logic             busy,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             result_valid
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  mdState            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  mulDivOperation    op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [TAG_W-1:0]  tag_out_q, tag_out_d;
  logic              result_valid_q, result_valid_d;

  mulDivOperation    op_in;
  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fin_res;

  assign op_in  = mulDivOperation'(op);
  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign busy   = (state_q == CALC) || (state_q == FINISH);
  assign accept = start && ready && !kill;

  assign a_neg = a_signed(op_in) && a[XLEN-1];
  assign b_neg = b_signed(op_in) && b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  mul_div_step #(.XLEN(XLEN)) u_step (
    .acc_i      (acc_q),
    .opnd_i     (opnd_q),
    .div_mode_i (is_div(op_q)),
    .acc_o      (step_acc)
  );

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      MUL:                 fin_res = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:           fin_res = quot_fix;
      default:             fin_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    op_d           = op_q;
    tag_d          = tag_q;
    acc_d          = acc_q;
    opnd_d         = opnd_q;
    neg_d          = neg_q;
    rem_neg_d      = rem_neg_q;
    result_d       = result_q;
    tag_out_d      = tag_out_q;
    result_valid_d = 1'b0;

    case (state_q)
      CALC: begin
        acc_d   = step_acc;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) state_d = FINISH;
      end
      FINISH: begin
        result_d       = fin_res;
        tag_out_d      = tag_q;
        result_valid_d = 1'b1;
        state_d        = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    if (accept) begin
      op_d      = op_in;
      tag_d     = tag_in;
      count_d   = '0;
      neg_d     = a_neg ^ b_neg;
      rem_neg_d = a_neg;
      opnd_d    = opnd_q;
      // Special cases preload the accumulator with the final answer and clear the sign fix.
      if (is_div(op_in) && (b == '0)) begin
        acc_d     = {a, {XLEN{1'b1}}};
        neg_d     = 1'b0;
        rem_neg_d = 1'b0;
        state_d   = FINISH;
      end else if (is_div(op_in) && b_signed(op_in) && (a == MIN_NEG) && (b == '1)) begin
        acc_d     = {{XLEN{1'b0}}, a};
        neg_d     = 1'b0;
        rem_neg_d = 1'b0;
        state_d   = FINISH;
      end else if (is_div(op_in)) begin
        acc_d   = {{XLEN{1'b0}}, a_mag};
        opnd_d  = b_mag;
        state_d = CALC;
      end else begin
        acc_d   = {{XLEN{1'b0}}, b_mag};
        opnd_d  = a_mag;
        state_d = CALC;
      end
    end

    if (kill) begin
      state_d        = IDLE;
      result_valid_d = 1'b0;
      result_d       = result_q;
      tag_out_d      = tag_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      op_q           <= MUL;
      tag_q          <= '0;
      acc_q          <= '0;
      opnd_q         <= '0;
      neg_q          <= 1'b0;
      rem_neg_q      <= 1'b0;
      result_q       <= '0;
      tag_out_q      <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      op_q           <= op_d;
      tag_q          <= tag_d;
      acc_q          <= acc_d;
      opnd_q         <= opnd_d;
      neg_q          <= neg_d;
      rem_neg_q      <= rem_neg_d;
      result_q       <= result_d;
      tag_out_q      <= tag_out_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result       = result_q;
  assign tag_out      = tag_out_q;
  assign result_valid = result_valid_q;

endmodule
